// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that catches a fetched word while decode is stalled.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_full,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_full;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_pc    <= 32'h0;
      r_instr <= 32'h0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full  <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight, drives IF/ID.
// Handshake: a request is accepted on an edge where imem_req && imem_ready; its single response
// arrives on a later cycle with imem_rvalid, and responses are never back-pressured.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [4:0]  if_id_rs1_addr,
  output logic [4:0]  if_id_rs2_addr,
  output state_e      dbg_state
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_req;
  logic        r_run;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_accept;
  logic        w_deliver;
  logic        w_push;
  logic        w_pop;
  logic        w_skid_full;
  logic [31:0] w_skid_pc;
  logic [31:0] w_skid_instr;
  logic [31:0] w_redirect_pc;
  logic        w_unused_bits;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

  // r_run holds the first request off until the cycle after reset is released.
  assign imem_req  = r_run && (r_state == S_IDLE) && !w_skid_full && !redirect_valid;
  assign imem_addr = {r_pc[31:2], 2'b00};
  assign w_accept  = imem_req && imem_ready;
  assign w_deliver = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign w_push    = w_deliver && stall;
  assign w_pop     = w_skid_full && !stall && !redirect_valid;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_pc    (r_pc_req),
    .i_instr (imem_rdata),
    .o_full  (w_skid_full),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_pc_req <= RESET_PC;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc <= w_redirect_pc;
        // A response still owed by memory must be swallowed before the next request.
        if ((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid) r_state <= S_DROP;
        else r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_state  <= S_WAIT;
            r_pc_req <= r_pc;
          end
          S_WAIT: if (imem_rvalid) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_IDLE;
          end
          S_DROP: if (imem_rvalid) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (stall) begin
      r_if_valid <= r_if_valid;
    end else if (w_skid_full) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= w_skid_pc;
      r_if_instr <= w_skid_instr;
    end else if (w_deliver) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_pc_req;
      r_if_instr <= imem_rdata;
    end else begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end
  end

  assign if_id_valid    = r_if_valid;
  assign if_id_pc       = r_if_pc;
  assign if_id_instr    = r_if_instr;
  assign if_id_rs1_addr = r_if_instr[19:15];
  assign if_id_rs2_addr = r_if_instr[24:20];
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for streaming/stall, hand sequences for redirect, wrap, reset.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  if_id_rs1_addr;
  logic [4:0]  if_id_rs2_addr;
  state_e      dbg_state;

  int checks   = 0;
  int failures = 0;

  // memory model state
  int          mem_lat = 1;
  logic [31:0] mem_xor = 32'h0000_00A5;
  logic        pend    = 1'b0;
  int          cnt     = 0;
  logic [31:0] paddr   = 32'h0;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[11];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_rs1_addr (if_id_rs1_addr),
    .if_id_rs2_addr (if_id_rs2_addr),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock edge; the memory model answers mem_lat cycles after an accepted request.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    acc = imem_req && imem_ready && !rst;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (acc) begin
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = paddr ^ mem_xor;
        pend        = 1'b0;
      end
    end
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    logic [31:0] ei;
    ei = instr;
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, "_instr"}, if_id_instr, instr);
    if (v) begin
      chk({tag, "_pc"}, if_id_pc, pc);
      chk({tag, "_rs1"}, 32'(if_id_rs1_addr), 32'(ei[19:15]));
      chk({tag, "_rs2"}, 32'(if_id_rs2_addr), 32'(ei[24:20]));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 32'h13};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h13};
    vecs[2]  = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0, 32'hA5};
    vecs[3]  = '{1'b0, 1'b0, 32'h4,  1'b0, 32'h0, 32'h13};
    vecs[4]  = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h4, 32'hA1};
    vecs[5]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4, 32'hA1};
    vecs[6]  = '{1'b1, 1'b0, 32'hC,  1'b1, 32'h4, 32'hA1};
    vecs[7]  = '{1'b1, 1'b0, 32'hC,  1'b1, 32'h4, 32'hA1};
    vecs[8]  = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h8, 32'hAD};
    vecs[9]  = '{1'b0, 1'b0, 32'hC,  1'b0, 32'h0, 32'h13};
    vecs[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC, 32'hA9};

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h13);
    chk("rst_pc", if_id_pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", 32'(imem_req), 32'h0);

    // streaming then a three-cycle stall while the word for pc=8 returns
    for (int i = 0; i < 11; i++) begin
      stall = vecs[i].stall;
      step();
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk_ifid($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr);
    end
    stall = 1'b0;

    // redirect while the pc=16 request is outstanding, memory latency 2
    mem_lat = 2;
    step();
    chk("t4_wait", 32'(dbg_state), 32'(S_WAIT));
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_drop", 32'(dbg_state), 32'(S_DROP));
    chk("t4_req0", 32'(imem_req), 32'h0);
    chk_ifid("t4_bub", 1'b0, 32'h0, 32'h13);
    step();
    chk("t4_req1", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h100);
    chk_ifid("t4_dropped", 1'b0, 32'h0, 32'h13);
    step();
    step();
    chk_ifid("t4_gap", 1'b0, 32'h0, 32'h13);
    step();
    chk_ifid("t4_tgt", 1'b1, 32'h100, 32'h1A5);

    // redirect and stall together while the skid holds pc=0x104
    mem_lat = 1;
    stall   = 1'b1;
    step();
    chk_ifid("t5_hold", 1'b1, 32'h100, 32'h1A5);
    step();
    chk("t5_skid_req", 32'(imem_req), 32'h0);
    chk_ifid("t5_hold2", 1'b1, 32'h100, 32'h1A5);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    chk_ifid("t5_bub", 1'b0, 32'h0, 32'h13);
    chk("t5_req", 32'(imem_req), 32'h1);
    chk("t5_addr", imem_addr, 32'h200);
    step();
    chk_ifid("t5_noskid", 1'b0, 32'h0, 32'h13);
    step();
    chk_ifid("t5_tgt", 1'b1, 32'h200, 32'h2A5);

    // redirect in S_IDLE suppresses the request; then fetch at the top of memory wraps
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t6_gate", 32'(imem_req), 32'h0);
    step();
    redirect_valid = 1'b0;
    mem_xor = 32'h00A5_80A5;
    #1;
    chk("t6_req", 32'(imem_req), 32'h1);
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk_ifid("t6_top", 1'b1, 32'hFFFF_FFFC, 32'hFF5A_7F59);
    chk("t6_rs1", 32'(if_id_rs1_addr), 32'd20);
    chk("t6_rs2", 32'(if_id_rs2_addr), 32'd21);
    chk("t6_wrap", imem_addr, 32'h0);

    // reset with a request in flight, then a stale response after release
    mem_xor = 32'h0000_00A5;
    mem_lat = 2;
    step();
    chk("t1_wait", 32'(dbg_state), 32'(S_WAIT));
    rst = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'h0);
    chk_ifid("t1_rst", 1'b0, 32'h0, 32'h13);
    chk("t1_state", 32'(dbg_state), 32'(S_IDLE));
    chk("t1_pc", imem_addr, 32'h0);
    step();
    step();
    rst = 1'b0;
    pend = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_rel_req", 32'(imem_req), 32'h0);
    mem_lat = 1;
    step();
    chk("t1_stale_state", 32'(dbg_state), 32'(S_IDLE));
    chk("t1_req1", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk_ifid("t1_stale", 1'b0, 32'h0, 32'h13);
    step();
    step();
    chk_ifid("t1_first", 1'b1, 32'h0, 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
